// File: rtl/mac_seq_ctrl_if.sv
// Bundle between mac_seq_ctrl and its neighbours: layer control,
// weight/operand buffers, MAC PE and the result stream sink.
interface mac_seq_ctrl_if #(
    parameter int ACC_W = 16,
    parameter int KW    = 7
);
    logic             start;
    logic [KW-1:0]    cfg_k;
    logic [3:0]       cfg_n;
    logic [1:0]       cfg_src;
    logic             op_avail;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [KW+2:0]    w_addr;
    logic             mac_clear;
    logic             mac_valid_0;
    logic             mac_valid_1;
    logic             mac_valid_2;
    logic [2:0]       mac_acc_sel;
    logic [ACC_W-1:0] mac_acc_out;
    logic             mac_valid_out;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [2:0]       res_idx;

    modport master (
        input  start, cfg_k, cfg_n, cfg_src, op_avail,
        input  mac_acc_out, mac_valid_out, res_ready,
        output busy, done, rd_en, w_addr, mac_clear,
        output mac_valid_0, mac_valid_1, mac_valid_2, mac_acc_sel,
        output res_valid, res_data, res_idx
    );

    modport slave (
        output start, cfg_k, cfg_n, cfg_src, op_avail,
        output mac_acc_out, mac_valid_out, res_ready,
        input  busy, done, rd_en, w_addr, mac_clear,
        input  mac_valid_0, mac_valid_1, mac_valid_2, mac_acc_sel,
        input  res_valid, res_data, res_idx
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one multi-accumulator MAC PE: clear, K*N ops,
// capture of final accumulators, then result streaming.
module mac_seq_ctrl #(
    parameter int ACC_W   = 16,
    parameter int NUM_ACC = 8,
    parameter int K_MAX   = 64,
    parameter int KW      = 7
) (
    input logic            clk,
    input logic            rst,
    mac_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, RUN, DRAIN, OUT, FIN
    } state_t;

    state_t state, state_nx;

    logic [KW-1:0]    k_reg, k_cnt, k_in;
    logic [3:0]       n_reg, n_in;
    logic [1:0]       src_reg, src_in;
    logic [2:0]       n_cnt, out_idx;
    logic             issue, last_n, last_k, last_out, accept;

    logic             s1_valid, s1_last;
    logic [2:0]       s1_idx;
    logic             s2_last;
    logic [2:0]       s2_idx;

    logic [ACC_W-1:0] result_buf [NUM_ACC];

    // Clamp the requested job shape and lane before latching
    always_comb begin
        k_in   = (bus.cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : bus.cfg_k;
        n_in   = (bus.cfg_n > 4'(NUM_ACC)) ? 4'(NUM_ACC) : bus.cfg_n;
        src_in = (bus.cfg_src == 2'd3) ? 2'd0 : bus.cfg_src;
    end

    // Position flags for the op counters and the output index
    always_comb begin
        issue    = (state == RUN) && bus.op_avail;
        last_n   = ({1'b0, n_cnt} == n_reg - 4'd1);
        last_k   = (k_cnt == k_reg - 1'b1);
        last_out = ({1'b0, out_idx} == n_reg - 4'd1);
        accept   = (state == OUT) && bus.res_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and all combinational outputs
    always_comb begin
        state_nx        = state;
        bus.busy        = (state != IDLE);
        bus.done        = 1'b0;
        bus.mac_clear   = 1'b0;
        bus.rd_en       = 1'b0;
        bus.w_addr      = '0;
        bus.res_valid   = 1'b0;
        bus.res_data    = '0;
        bus.res_idx     = '0;
        bus.mac_valid_0 = s1_valid && (src_reg == 2'd0);
        bus.mac_valid_1 = s1_valid && (src_reg == 2'd1);
        bus.mac_valid_2 = s1_valid && (src_reg == 2'd2);
        bus.mac_acc_sel = s1_idx;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (k_in == '0 || n_in == '0) state_nx = FIN;
                    else                          state_nx = CLEAR;
                end
            end
            CLEAR: begin
                bus.mac_clear = 1'b1;
                state_nx      = RUN;
            end
            RUN: begin
                bus.rd_en = issue;
                if (issue) bus.w_addr = {k_cnt, n_cnt};
                if (issue && last_n && last_k) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid) state_nx = OUT;
            end
            OUT: begin
                bus.res_valid = 1'b1;
                bus.res_data  = result_buf[out_idx];
                bus.res_idx   = out_idx;
                if (accept && last_out) state_nx = FIN;
            end
            FIN: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched job configuration and the k/n/out counters
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg   <= '0;
            n_reg   <= '0;
            src_reg <= '0;
            k_cnt   <= '0;
            n_cnt   <= '0;
            out_idx <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                k_reg   <= k_in;
                n_reg   <= n_in;
                src_reg <= src_in;
            end
            if (state == CLEAR) begin
                k_cnt <= '0;
                n_cnt <= '0;
            end else if (issue) begin
                if (last_n) begin
                    n_cnt <= '0;
                    k_cnt <= k_cnt + 1'b1;
                end else begin
                    n_cnt <= n_cnt + 1'b1;
                end
            end
            if (state == DRAIN)  out_idx <= '0;
            else if (accept)     out_idx <= out_idx + 1'b1;
        end
    end

    // Tag pipeline following each op through buffer read and MAC
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            s2_last  <= 1'b0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue && last_k;
            s1_idx   <= issue ? n_cnt : 3'd0;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
        end
    end

    // Keep only the final-step accumulator value of each index
    always_ff @(posedge clk) begin
        if (bus.mac_valid_out && s2_last)
            result_buf[s2_idx] <= bus.mac_acc_out;
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural
// operand buffer and 1-cycle-latency MAC model.
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.ACC_W(16), .KW(7)) bus ();

    mac_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int data;
    } res_t;

    res_t sb[$];
    int   waddr_log[$];

    int checks   = 0;
    int failures = 0;

    int rd_cnt = 0, rd_viol = 0, clr_cnt = 0, clr_viol = 0;
    int lane_cnt [3] = '{0, 0, 0};
    int done_cnt = 0, acc_cnt = 0;

    bit stall_mode = 0;
    int bp_req     = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [39:0] outs();
        return {bus.busy, bus.done, bus.rd_en, bus.w_addr,
                bus.mac_clear, bus.mac_valid_0, bus.mac_valid_1,
                bus.mac_valid_2, bus.mac_acc_sel, bus.res_valid,
                bus.res_data, bus.res_idx};
    endfunction

    // Operand buffer (operand 2, weight n+1) and MAC PE model
    logic [15:0] op_q, w_q;
    logic [15:0] acc [8];
    logic [15:0] sum;
    always @(posedge clk) begin
        if (bus.rd_en) begin
            op_q <= 16'd2;
            w_q  <= 16'(bus.w_addr[2:0]) + 16'd1;
        end
        sum = acc[bus.mac_acc_sel] + op_q * w_q;
        bus.mac_valid_out <= 1'b0;
        if (bus.mac_clear) begin
            for (int i = 0; i < 8; i++) acc[i] <= '0;
        end else if (bus.mac_valid_0 || bus.mac_valid_1 || bus.mac_valid_2) begin
            acc[bus.mac_acc_sel] <= sum;
            bus.mac_acc_out      <= sum;
            bus.mac_valid_out    <= 1'b1;
        end
    end

    // Operand availability: always, or the 1,0,0 stall pattern
    initial begin
        int ph = 0;
        bus.op_avail = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode) begin
                bus.op_avail = (ph % 3 == 0);
                ph++;
            end else begin
                bus.op_avail = 1'b1;
            end
        end
    end

    // Result sink: on request, hold ready low 5 cycles at first valid
    initial begin
        int served = 0;
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_req > served && bus.res_valid) begin
                served = bp_req;
                bus.res_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                bus.res_ready = 1'b1;
            end
        end
    end

    // Monitor: activity counters, hold checks and scoreboard pops
    initial begin
        bit          prev_stall = 0;
        logic [15:0] prev_data  = '0;
        logic [2:0]  prev_idx   = '0;
        res_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (bus.rd_en) begin
                    rd_cnt++;
                    waddr_log.push_back(int'(bus.w_addr));
                end
                if (bus.rd_en && !bus.op_avail) rd_viol++;
                if (bus.mac_clear) clr_cnt++;
                if (bus.mac_clear && (bus.mac_valid_0 || bus.mac_valid_1 || bus.mac_valid_2))
                    clr_viol++;
                if (bus.mac_valid_0) lane_cnt[0]++;
                if (bus.mac_valid_1) lane_cnt[1]++;
                if (bus.mac_valid_2) lane_cnt[2]++;
                if (bus.done) done_cnt++;
                if (prev_stall && bus.res_valid) begin
                    chk("hold_data", bus.res_data, prev_data);
                    chk("hold_idx", bus.res_idx, prev_idx);
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                prev_data  = bus.res_data;
                prev_idx   = bus.res_idx;
                if (bus.res_valid && bus.res_ready) begin
                    acc_cnt++;
                    chk("sb_has_entry", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("res_idx", bus.res_idx, e.idx);
                        chk("res_data", bus.res_data, e.data);
                    end
                end
            end
        end
    end

    task automatic start_job(input int k, input int n, input int src);
        bus.cfg_k   = 7'(k);
        bus.cfg_n   = 4'(n);
        bus.cfg_src = 2'(src);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int lat, output bit ok);
        lat = 1;
        ok  = 0;
        while (lat <= bound) begin
            if (bus.done) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic push_res(input int idx, input int data);
        res_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_job(input int k, input int n, input int src,
                          input int lane, input int n_ops,
                          input int n_res, input int exp_lat);
        int rd0 = rd_cnt, clr0 = clr_cnt, cv0 = clr_viol, rv0 = rd_viol;
        int l0 = lane_cnt[0], l1 = lane_cnt[1], l2 = lane_cnt[2];
        int d0 = done_cnt, a0 = acc_cnt;
        int lat;
        bit ok;
        start_job(k, n, src);
        wait_done(2000, lat, ok);
        chk("done_seen", ok, 1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        @(posedge clk); #1;
        chk("busy_after_done", bus.busy, 0);
        chk("rd_ops", rd_cnt - rd0, n_ops);
        chk("rd_while_stalled", rd_viol - rv0, 0);
        chk("clear_pulses", clr_cnt - clr0, (n_ops > 0) ? 1 : 0);
        chk("valid_with_clear", clr_viol - cv0, 0);
        chk("lane0", lane_cnt[0] - l0, (lane == 0) ? n_ops : 0);
        chk("lane1", lane_cnt[1] - l1, (lane == 1) ? n_ops : 0);
        chk("lane2", lane_cnt[2] - l2, (lane == 2) ? n_ops : 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("results_out", acc_cnt - a0, n_res);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat, d0, a0, cnt;
        bit ok;
        int exp_wa [6] = '{0, 1, 8, 9, 16, 17};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_k = '0;
        bus.cfg_n = '0;
        bus.cfg_src = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", outs(), 0);

        // 1: basic job
        base = waddr_log.size();
        push_res(0, 6);
        push_res(1, 12);
        do_job(3, 2, 1, 1, 6, 2, 12);
        chk("waddr_count", waddr_log.size() - base, 6);
        for (int i = 0; i < 6; i++)
            if (base + i < waddr_log.size())
                chk("waddr_seq", waddr_log[base + i], exp_wa[i]);

        // 2: operand stall
        stall_mode = 1;
        push_res(0, 6);
        push_res(1, 12);
        do_job(3, 2, 1, 1, 6, 2, -1);
        stall_mode = 0;

        // 3: output backpressure, 5 extra cycles in OUT
        bp_req = 1;
        push_res(0, 6);
        push_res(1, 12);
        do_job(3, 2, 1, 1, 6, 2, 17);

        // 4: degenerate and boundary configurations
        do_job(3, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) push_res(i, 4 * (i + 1));
        do_job(2, 12, 2, 2, 16, 8, 28);
        for (int i = 0; i < 8; i++) push_res(i, 128 * (i + 1));
        do_job(64, 8, 1, 1, 512, 8, 524);
        chk("last_waddr", waddr_log[waddr_log.size() - 1], 511);
        push_res(0, 2);
        do_job(1, 1, 3, 0, 1, 1, 6);

        // 5: reset at k=1 of the basic job
        d0 = done_cnt;
        start_job(3, 2, 1);
        cnt = 0;
        while (!(bus.rd_en && bus.w_addr == 10'd8) && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("reached_k1", cnt < 20, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs", outs(), 0);
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("no_done_after_abort", done_cnt - d0, 0);
        chk("sb_after_abort", sb.size(), 0);
        push_res(0, 6);
        push_res(1, 12);
        do_job(3, 2, 1, 1, 6, 2, 12);

        // 6: start during OUT is ignored
        d0 = done_cnt;
        a0 = acc_cnt;
        push_res(0, 6);
        push_res(1, 12);
        start_job(3, 2, 1);
        cnt = 0;
        while (!bus.res_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("reached_out", bus.res_valid, 1);
        start_job(3, 5, 1);
        wait_done(50, lat, ok);
        chk("busy_job_done", ok, 1);
        @(posedge clk); #1;
        chk("busy_job_results", acc_cnt - a0, 2);
        chk("busy_job_done_cnt", done_cnt - d0, 1);
        chk("busy_job_idle", bus.busy, 0);
        push_res(0, 6);
        push_res(1, 12);
        do_job(3, 2, 1, 1, 6, 2, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for one multi-accumulator MAC PE.
- Runs a job of K reduction steps over N accumulators: clears the MAC, then issues one MAC op per (k,n) with the correct lane valid, accumulator select and weight/operand read strobes.
- Captures the final accumulator values into a local result buffer and streams them out over a valid/ready port.
- Sits between the weight/operand buffers and the MAC PE, under the layer-level control FSM.

Parameters:
- ACC_W, 16, accumulator/result width.
- NUM_ACC, 8, number of MAC accumulators (acc_sel width is 3).
- K_MAX, 64, maximum reduction length.
- KW, 7, width of cfg_k; holds 1..K_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job start pulse; honoured only in IDLE
- cfg_k  in  KW  reduction length, sampled on accepted start
- cfg_n  in  4  accumulators used, sampled on accepted start
- cfg_src  in  2  input lane to drive (0..2)
- op_avail  in  1  operand and weight for the next op are available
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- rd_en  out  1  read strobe to weight and operand buffers
- w_addr  out  KW+3  weight address, equal to k*NUM_ACC+n
- mac_clear  out  1  to MAC clear
- mac_valid_0, mac_valid_1, mac_valid_2  out  1 each  to MAC lane valids
- mac_acc_sel  out  3  to MAC acc_sel
- mac_acc_out  in  ACC_W  from MAC acc_out
- mac_valid_out  in  1  from MAC valid_out
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  ACC_W  result value
- res_idx  out  3  accumulator index of res_data

Behaviour:
- Reset: the state machine returns to IDLE. The following outputs all go to 0:
  - busy, done, rd_en, w_addr
  - mac_clear, mac_valid_0/1/2, mac_acc_sel
  - res_valid, res_data, res_idx
- Reset clears all counters and pipeline tags. The result buffer contents are don't-care after reset.
- Reset mid-job aborts the job immediately. No done pulse is generated.
- States: IDLE, CLEAR, RUN, DRAIN, OUT, FIN.
- IDLE:
  - On start, latch the configuration, with these adjustments:
    - cfg_n above NUM_ACC is clamped to NUM_ACC.
    - cfg_k above K_MAX is clamped to K_MAX.
    - cfg_src=3 is treated as lane 0.
  - If the latched k or n is 0, go to FIN with no MAC activity.
  - Otherwise go to CLEAR.
  - start is ignored in every state other than IDLE.
- CLEAR:
  - Assert mac_clear for exactly 1 cycle.
  - Reset k_cnt and n_cnt to 0, then go to RUN.
- RUN:
  - In each cycle with op_avail=1, issue stage 0: rd_en=1 and w_addr=k_cnt*NUM_ACC+n_cnt.
  - Then advance n_cnt. When n_cnt wraps from N-1 to 0, increment k_cnt.
  - If op_avail=0, do not issue; the counters hold.
  - After the op with k=K-1 and n=N-1 is issued, go to DRAIN.
- Stage 1 (registered, 1 cycle after rd_en; data is returned by the buffers at this point):
  - Exactly the selected mac_valid_<cfg_src> is 1, and mac_acc_sel=n.
  - A last tag (k==K-1) and the index n are carried alongside.
  - No mac_valid is ever asserted in the same cycle as mac_clear.
- Capture (MAC latency 1, so 2 cycles after rd_en):
  - When mac_valid_out=1 and the stage-2 last tag is set, write result_buf[idx]=mac_acc_out.
  - All other mac_valid_out cycles are ignored.
- DRAIN:
  - Wait until stages 1 and 2 are empty (2 cycles), then go to OUT with out_idx=0.
- OUT:
  - res_valid=1, res_data=result_buf[out_idx], res_idx=out_idx.
  - On res_valid&&res_ready, increment out_idx. After index N-1 is accepted, go to FIN.
  - res_data and res_idx stay stable while res_valid=1 and res_ready=0.
- FIN: done=1 for 1 cycle, then go to IDLE (busy low from the next cycle).
- Arithmetic: the controller adds no arithmetic. Results are the MAC's ACC_W wrap-around sums, passed through unmodified.
- Throughput: with op_avail held high, RUN lasts exactly K*N cycles.
- Job latency from accepted start to done, with op_avail and res_ready held high: 1 (CLEAR) + K*N (RUN) + 2 (DRAIN) + N (OUT) + 1 (FIN) cycles.

Test Plan:
1. Basic job: cfg_k=3, cfg_n=2, cfg_src=1; all operands=2; weights w[k*8+n]=n+1; op_avail and res_ready held high.
   - mac_valid_1 is the only lane ever asserted; mac_clear pulses once before any valid.
   - w_addr sequence is 0,1,8,9,16,17.
   - Results are (idx0,6) then (idx1,12); done arrives at cycle 1+6+2+2+1 after start.
2. Operand stall: same job, with op_avail toggling 1,0,0,1,...
   - No rd_en while op_avail=0; counters hold.
   - Results are identical to test 1.
3. Output backpressure: res_ready held low for 5 cycles during OUT.
   - res_valid stays high, with res_data and res_idx stable.
   - No result is lost or duplicated.
4. Degenerate and boundary configuration:
   - cfg_n=0: done arrives 1 cycle after start; no mac_clear, rd_en or res_valid.
   - cfg_n=12: clamped to 8 results.
   - cfg_k=64: last w_addr=511.
   - cfg_src=3: drives mac_valid_0.
5. Reset mid-RUN: assert rst at k=1 of the test 1 job.
   - All outputs go to 0 next cycle; no done pulse.
   - A following start with the same job produces the test 1 results exactly.
6. start while busy: pulse start with cfg_n=5 during OUT.
   - Ignored: the current job completes with N=2.
   - A start issued after done runs normally.
